// File: rtl/fetcher_if.sv
// Program-memory read channel between the fetcher (master) and instruction memory (slave).
// Latency: none (wires only).
// Backpressure: master holds valid/address until the slave strobes ready.
// Signals: mem_read_valid/mem_read_address (master -> memory),
//          mem_read_ready/mem_read_data (memory -> master).
interface fetcher_if #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 16
);
   logic                 mem_read_valid;
   logic [ADDR_BITS-1:0] mem_read_address;
   logic                 mem_read_ready;
   logic [DATA_BITS-1:0] mem_read_data;

   modport master (
      output mem_read_valid,
      output mem_read_address,
      input  mem_read_ready,
      input  mem_read_data
   );

   modport slave (
      input  mem_read_valid,
      input  mem_read_address,
      output mem_read_ready,
      output mem_read_data
   );
endinterface

// File: rtl/fetcher.sv
// Instruction fetcher: issues one program-memory read per core FETCH and latches the word.
// Latency: request visible one cycle after FETCH is sampled; instruction one cycle after ready.
// Backpressure: request held stable until ready; gives up with a sticky error after TIMEOUT_CYCLES.
// Ports: clk, reset (async, active-high), enable, core_state, current_pc,
//        mem (fetcher_if.master), fetcher_state, instruction, fetch_error.
module fetcher #(
   parameter int PROGRAM_MEM_ADDR_BITS = 8,
   parameter int PROGRAM_MEM_DATA_BITS = 16,
   parameter int TIMEOUT_CYCLES        = 255
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             enable,
   input  logic [2:0]                       core_state,
   input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
   fetcher_if.master                        mem,
   output logic [2:0]                       fetcher_state,
   output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
   output logic                             fetch_error
);

   localparam logic [2:0] CORE_FETCH  = 3'b001;
   localparam logic [2:0] CORE_DECODE = 3'b010;

   // Timeout fires on the edge where the counter already holds TIMEOUT_CYCLES-1,
   // i.e. on the TIMEOUT_CYCLES-th FETCHING edge without ready.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'b000,
      FETCHING = 3'b001,
      FETCHED  = 3'b010,
      ERROR    = 3'b011
   } state_t;

   state_t                             state_q, state_d;
   logic                               valid_q, valid_d;
   logic [PROGRAM_MEM_ADDR_BITS-1:0]   addr_q,  addr_d;
   logic [PROGRAM_MEM_DATA_BITS-1:0]   instr_q, instr_d;
   logic                               err_q,   err_d;
   logic [7:0]                         cnt_q,   cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         addr_q  <= '0;
         instr_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            // enable only gates starting a fetch; an in-flight fetch always completes.
            if (enable && core_state == CORE_FETCH) begin
               state_d = FETCHING;
               valid_d = 1'b1;
               addr_d  = current_pc;
               cnt_d   = '0;
            end
         end
         FETCHING: begin
            // ready takes priority over a timeout landing on the same edge.
            if (mem.mem_read_ready) begin
               instr_d = mem.mem_read_data;
               valid_d = 1'b0;
               state_d = FETCHED;
            end else if (cnt_q == TIMEOUT_LAST) begin
               valid_d = 1'b0;
               err_d   = 1'b1;
               state_d = ERROR;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         FETCHED: begin
            if (core_state == CORE_DECODE) begin
               state_d = IDLE;
            end
         end
         ERROR: begin
            // Terminal until reset.
            valid_d = 1'b0;
            err_d   = 1'b1;
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   assign mem.mem_read_valid   = valid_q;
   assign mem.mem_read_address = addr_q;
   assign fetcher_state        = state_q;
   assign instruction          = instr_q;
   assign fetch_error          = err_q;

endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher: one default-timeout instance and one with TIMEOUT_CYCLES=4,
// both driven by the same stimulus.
// Status word per instance: {fetcher_state, valid, address, instruction, fetch_error}.
module tb_fetcher;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [2:0]  core_state;
   logic [7:0]  current_pc;
   logic        ready;
   logic [15:0] rdata;

   logic [2:0]  st_a, st_b;
   logic [15:0] instr_a, instr_b;
   logic        err_a, err_b;

   int checks;
   int passes;

   localparam logic [2:0] CS_FETCH  = 3'b001;
   localparam logic [2:0] CS_DECODE = 3'b010;

   fetcher_if #(.ADDR_BITS(8), .DATA_BITS(16)) bus_a ();
   fetcher_if #(.ADDR_BITS(8), .DATA_BITS(16)) bus_b ();

   assign bus_a.mem_read_ready = ready;
   assign bus_a.mem_read_data  = rdata;
   assign bus_b.mem_read_ready = ready;
   assign bus_b.mem_read_data  = rdata;

   fetcher u_dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .core_state    (core_state),
      .current_pc    (current_pc),
      .mem           (bus_a),
      .fetcher_state (st_a),
      .instruction   (instr_a),
      .fetch_error   (err_a)
   );

   fetcher #(.TIMEOUT_CYCLES(4)) u_dut_to (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .core_state    (core_state),
      .current_pc    (current_pc),
      .mem           (bus_b),
      .fetcher_state (st_b),
      .instruction   (instr_b),
      .fetch_error   (err_b)
   );

   wire [28:0] stat_a = {st_a, bus_a.mem_read_valid, bus_a.mem_read_address, instr_a, err_a};
   wire [28:0] stat_b = {st_b, bus_b.mem_read_valid, bus_b.mem_read_address, instr_b, err_b};
   // Address is not constrained once in ERROR, so error checks use this narrower word.
   wire [20:0] err_stat_b = {st_b, bus_b.mem_read_valid, err_b, instr_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      enable     = 1'b0;
      core_state = 3'b000;
      current_pc = 8'h00;
      ready      = 1'b0;
      rdata      = 16'h0000;
      cyc();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [28:0] e;
      reset      = 1'b1;
      enable     = 1'b1;
      core_state = CS_FETCH;
      current_pc = 8'h7F;
      ready      = 1'b1;
      rdata      = 16'hFFFF;
      #1;
      e = {3'd0, 1'b0, 8'h00, 16'h0000, 1'b0};
      checks++;
      if (stat_a !== e) $display("FAIL reset_async: got %h expected %h", stat_a, e);
      else passes++;
      cyc();
      cyc();
      checks++;
      if (stat_a !== e) $display("FAIL reset_held_a: got %h expected %h", stat_a, e);
      else passes++;
      checks++;
      if (stat_b !== e) $display("FAIL reset_held_b: got %h expected %h", stat_b, e);
      else passes++;
      do_reset();
   endtask

   task automatic test_basic();
      logic [28:0] e;
      current_pc = 8'h05;
      enable     = 1'b1;
      core_state = CS_FETCH;
      cyc();
      e = {3'd1, 1'b1, 8'h05, 16'h0000, 1'b0};
      checks++;
      if (stat_a !== e) $display("FAIL basic_request: got %h expected %h", stat_a, e);
      else passes++;
      ready      = 1'b1;
      rdata      = 16'hA1B2;
      core_state = 3'b000;
      enable     = 1'b0;
      cyc();
      e = {3'd2, 1'b0, 8'h05, 16'hA1B2, 1'b0};
      checks++;
      if (stat_a !== e) $display("FAIL basic_fetched: got %h expected %h", stat_a, e);
      else passes++;
      ready      = 1'b0;
      core_state = 3'b100;
      cyc();
      checks++;
      if (stat_a !== e) $display("FAIL basic_hold_fetched: got %h expected %h", stat_a, e);
      else passes++;
      core_state = CS_DECODE;
      cyc();
      e = {3'd0, 1'b0, 8'h05, 16'hA1B2, 1'b0};
      checks++;
      if (stat_a !== e) $display("FAIL basic_decode_idle: got %h expected %h", stat_a, e);
      else passes++;
      // ready in IDLE, with enable but no FETCH, must change nothing
      ready      = 1'b1;
      rdata      = 16'h5555;
      enable     = 1'b1;
      core_state = 3'b000;
      cyc();
      checks++;
      if (stat_a !== e) $display("FAIL idle_ignores_ready: got %h expected %h", stat_a, e);
      else passes++;
      ready = 1'b0;
   endtask

   task automatic test_stall();
      logic [28:0] e;
      logic [20:0] eb;
      current_pc = 8'h05;
      enable     = 1'b1;
      core_state = CS_FETCH;
      cyc();
      current_pc = 8'h09;
      core_state = 3'b000;
      e = {3'd1, 1'b1, 8'h05, 16'hA1B2, 1'b0};
      for (int i = 0; i < 10; i++) begin
         cyc();
         checks++;
         if (stat_a !== e) $display("FAIL stall_cycle_%0d: got %h expected %h", i, stat_a, e);
         else passes++;
      end
      eb = {3'd3, 1'b0, 1'b1, 16'hA1B2};
      checks++;
      if (err_stat_b !== eb) $display("FAIL stall_short_timeout: got %h expected %h", err_stat_b, eb);
      else passes++;
      ready = 1'b1;
      rdata = 16'h1234;
      cyc();
      e = {3'd2, 1'b0, 8'h05, 16'h1234, 1'b0};
      checks++;
      if (stat_a !== e) $display("FAIL stall_latch: got %h expected %h", stat_a, e);
      else passes++;
      checks++;
      if (err_stat_b !== eb) $display("FAIL error_ignores_ready: got %h expected %h", err_stat_b, eb);
      else passes++;
      ready = 1'b0;
   endtask

   task automatic test_timeout();
      logic [28:0] e;
      logic [20:0] eb;
      do_reset();
      current_pc = 8'h33;
      enable     = 1'b1;
      core_state = CS_FETCH;
      cyc();
      core_state = 3'b000;
      cyc();
      cyc();
      cyc();
      e = {3'd1, 1'b1, 8'h33, 16'h0000, 1'b0};
      checks++;
      if (stat_b !== e) $display("FAIL timeout_3rd_edge: got %h expected %h", stat_b, e);
      else passes++;
      cyc();
      eb = {3'd3, 1'b0, 1'b1, 16'h0000};
      checks++;
      if (err_stat_b !== eb) $display("FAIL timeout_4th_edge: got %h expected %h", err_stat_b, eb);
      else passes++;
      enable     = 1'b1;
      core_state = CS_FETCH;
      ready      = 1'b1;
      rdata      = 16'hFFFF;
      cyc();
      cyc();
      cyc();
      checks++;
      if (err_stat_b !== eb) $display("FAIL timeout_terminal: got %h expected %h", err_stat_b, eb);
      else passes++;
      ready = 1'b0;
   endtask

   task automatic test_race();
      logic [28:0] e;
      do_reset();
      current_pc = 8'h21;
      enable     = 1'b1;
      core_state = CS_FETCH;
      cyc();
      core_state = 3'b000;
      cyc();
      cyc();
      cyc();
      ready = 1'b1;
      rdata = 16'hBEEF;
      cyc();
      e = {3'd2, 1'b0, 8'h21, 16'hBEEF, 1'b0};
      checks++;
      if (stat_b !== e) $display("FAIL race_ready_wins: got %h expected %h", stat_b, e);
      else passes++;
      ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [28:0] e;
      do_reset();
      current_pc = 8'h44;
      enable     = 1'b1;
      core_state = CS_FETCH;
      cyc();
      e = {3'd1, 1'b1, 8'h44, 16'h0000, 1'b0};
      checks++;
      if (stat_a !== e) $display("FAIL midreset_request: got %h expected %h", stat_a, e);
      else passes++;
      #2;
      reset = 1'b1;
      #1;
      e = {3'd0, 1'b0, 8'h00, 16'h0000, 1'b0};
      checks++;
      if (stat_a !== e) $display("FAIL midreset_async_clear: got %h expected %h", stat_a, e);
      else passes++;
      current_pc = 8'h00;
      reset      = 1'b0;
      cyc();
      e = {3'd1, 1'b1, 8'h00, 16'h0000, 1'b0};
      checks++;
      if (stat_a !== e) $display("FAIL midreset_refetch: got %h expected %h", stat_a, e);
      else passes++;
      ready      = 1'b1;
      rdata      = 16'h5A5A;
      core_state = 3'b000;
      cyc();
      e = {3'd2, 1'b0, 8'h00, 16'h5A5A, 1'b0};
      checks++;
      if (stat_a !== e) $display("FAIL midreset_complete: got %h expected %h", stat_a, e);
      else passes++;
      ready = 1'b0;
   endtask

   task automatic test_gating();
      logic [28:0] e;
      do_reset();
      current_pc = 8'h12;
      enable     = 1'b0;
      core_state = CS_FETCH;
      cyc();
      cyc();
      cyc();
      e = {3'd0, 1'b0, 8'h00, 16'h0000, 1'b0};
      checks++;
      if (stat_a !== e) $display("FAIL gating_disabled_idle: got %h expected %h", stat_a, e);
      else passes++;
      enable = 1'b1;
      cyc();
      e = {3'd1, 1'b1, 8'h12, 16'h0000, 1'b0};
      checks++;
      if (stat_a !== e) $display("FAIL gating_enabled_start: got %h expected %h", stat_a, e);
      else passes++;
      enable     = 1'b0;
      core_state = 3'b000;
      cyc();
      checks++;
      if (stat_a !== e) $display("FAIL gating_no_abort: got %h expected %h", stat_a, e);
      else passes++;
      ready = 1'b1;
      rdata = 16'hC3C3;
      cyc();
      e = {3'd2, 1'b0, 8'h12, 16'hC3C3, 1'b0};
      checks++;
      if (stat_a !== e) $display("FAIL gating_complete: got %h expected %h", stat_a, e);
      else passes++;
      ready = 1'b0;
   endtask

   initial begin
      checks = 0;
      passes = 0;
      test_reset();
      test_basic();
      test_stall();
      test_timeout();
      test_race();
      test_reset_mid();
      test_gating();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/fetcher.md
FETCHER -- requirements
Module: fetcher

Interface
REQ-001 Parameter PROGRAM_MEM_ADDR_BITS, default 8: program-memory address width; equals PC width.
REQ-002 Parameter PROGRAM_MEM_DATA_BITS, default 16: instruction word width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: max FETCHING cycles without mem_read_ready before error; legal range 2..255.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 enable  input  1  block enable from core; gates only the start of a new fetch.
REQ-007 core_state  input  3  scheduler state; FETCH=3'b001, DECODE=3'b010, others ignored.
REQ-008 current_pc  input  PROGRAM_MEM_ADDR_BITS  PC to fetch, driven by the PC/NZP unit's next_pc.
REQ-009 mem_read_valid  output  1  read request to program memory.
REQ-010 mem_read_address  output  PROGRAM_MEM_ADDR_BITS  read address, registered.
REQ-011 mem_read_ready  input  1  memory response strobe; mem_read_data valid when high.
REQ-012 mem_read_data  input  PROGRAM_MEM_DATA_BITS  instruction word from memory.
REQ-013 fetcher_state  output  3  IDLE=3'b000, FETCHING=3'b001, FETCHED=3'b010, ERROR=3'b011.
REQ-014 instruction  output  PROGRAM_MEM_DATA_BITS  latched instruction to decoder.
REQ-015 fetch_error  output  1  sticky timeout flag.

Function
REQ-016 All outputs and internal state SHALL be registered; no combinational input-to-output path.
REQ-017 IDLE: enable=1 and core_state=FETCH on an edge -> next cycle mem_read_valid=1, mem_read_address=current_pc, FETCHING, timeout counter=0.
REQ-018 IDLE with enable=0 or core_state!=FETCH SHALL hold state; mem_read_ready in IDLE SHALL be ignored.
REQ-019 FETCHING: mem_read_valid and mem_read_address SHALL stay constant until ready sampled or timeout; current_pc changes SHALL not affect them.
REQ-020 FETCHING with mem_read_ready=1 on an edge -> instruction=mem_read_data, mem_read_valid=0, FETCHED, next cycle.
REQ-021 Minimum latency: FETCH sampled at edge N, valid high after N, ready sampled at N+1, instruction/FETCHED visible after N+1.
REQ-022 FETCHING without ready SHALL increment an 8-bit counter per cycle; on the edge the counter equals TIMEOUT_CYCLES-1 with ready low -> mem_read_valid=0, fetch_error=1, ERROR.
REQ-023 ready and timeout on same edge: ready wins; instruction latched, FETCHED, fetch_error stays 0.
REQ-024 enable deasserted during FETCHING SHALL NOT abort; handshake completes normally.
REQ-025 FETCHED: instruction held; core_state=DECODE on an edge -> IDLE next cycle; other core_state values hold FETCHED.
REQ-026 instruction SHALL hold its value through IDLE and the next FETCHING; updated only by REQ-020.
REQ-027 ERROR SHALL be terminal until reset; mem_read_valid=0, fetch_error=1, all other inputs ignored.
REQ-028 Counter SHALL never wrap; undefined fetcher_state encodings SHALL go to IDLE next edge.

Reset
REQ-029 reset high (async, any state incl. mid-handshake) SHALL immediately force fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0, fetch_error=0, counter=0.
REQ-030 First fetch after reset release SHALL need a fresh core_state=FETCH with enable=1.

Verification
REQ-031 Basic: current_pc=8'h05, FETCH, ready one cycle after valid with data 16'hA1B2 -> address 8'h05, instruction=16'hA1B2, FETCHED; DECODE -> IDLE.
REQ-032 Stall: ready held low 10 cycles, current_pc changed to 8'h09 meanwhile -> valid and address 8'h05 stable throughout; data latched on ready cycle.
REQ-033 Timeout: TIMEOUT_CYCLES=4, ready never asserted -> ERROR and fetch_error=1 after 4th FETCHING edge, valid=0; later FETCH ignored.
REQ-034 Race: TIMEOUT_CYCLES=4, ready on exactly the 4th FETCHING edge -> FETCHED, fetch_error=0.
REQ-035 Reset mid-fetch: reset asserted in FETCHING -> outputs zero without clock edge; after release, FETCH at PC 8'h00 completes normally.
REQ-036 Gating: enable=0 with core_state=FETCH -> IDLE held, valid stays 0; enable dropped during FETCHING -> fetch still completes.
